// File: rtl/wb_port_arbiter.sv
// Three-way round-robin arbiter feeding a single registered ROB writeback port.
// A stalled writeback stays in the output register until the ROB accepts it.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

module wb_port_arbiter #(
   parameter int unsigned WORD_SIZE       = `WORD_SIZE,
   parameter int unsigned INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
   parameter int unsigned ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [2:0]                   req_valid,
   input  logic [3*INSTR_TYPE_SZ-1:0]   req_instruction_type,
   input  logic [3*WORD_SIZE-1:0]       req_pc,
   input  logic [2:0]                   req_exception,
   input  logic [3*WORD_SIZE-1:0]       req_virtual_addr_exception,
   input  logic [3*WORD_SIZE-1:0]       req_aluResult,
   input  logic [3*ROB_ENTRY_WIDTH-1:0] req_rob_id,
   input  logic                         wb_stall,
   output logic [2:0]                   req_stall,
   output logic [INSTR_TYPE_SZ-1:0]     instruction_type_out,
   output logic [WORD_SIZE-1:0]         pc_out,
   output logic                         exception_out,
   output logic [WORD_SIZE-1:0]         virtual_addr_exception_out,
   output logic [WORD_SIZE-1:0]         aluResult_out,
   output logic [ROB_ENTRY_WIDTH-1:0]   rob_id_out,
   output logic                         valid_out,
   output logic [2:0]                   grant_out
);

   // Declaration initialisers give the reset values at time 0.
   logic [1:0]                 rr_ptr   = '0;
   logic [INSTR_TYPE_SZ-1:0]   itype_q  = '0;
   logic [WORD_SIZE-1:0]       pc_q     = '0;
   logic                       exc_q    = 1'b0;
   logic [WORD_SIZE-1:0]       vaddr_q  = '0;
   logic [WORD_SIZE-1:0]       result_q = '0;
   logic [ROB_ENTRY_WIDTH-1:0] rob_q    = '0;
   logic                       valid_q  = 1'b0;
   logic [2:0]                 grant_q  = '0;

   logic                       accept;
   logic [2:0]                 grant;
   logic [1:0]                 rr_ptr_next;
   logic [INSTR_TYPE_SZ-1:0]   sel_itype;
   logic [WORD_SIZE-1:0]       sel_pc;
   logic                       sel_exc;
   logic [WORD_SIZE-1:0]       sel_vaddr;
   logic [WORD_SIZE-1:0]       sel_result;
   logic [ROB_ENTRY_WIDTH-1:0] sel_rob;

   assign accept = !wb_stall || !valid_q;

   always_comb begin
      grant = 3'b000;
      if (!reset && accept) begin
         case (rr_ptr)
            2'd1: begin
               if (req_valid[1])      grant = 3'b010;
               else if (req_valid[2]) grant = 3'b100;
               else if (req_valid[0]) grant = 3'b001;
            end
            2'd2: begin
               if (req_valid[2])      grant = 3'b100;
               else if (req_valid[0]) grant = 3'b001;
               else if (req_valid[1]) grant = 3'b010;
            end
            default: begin
               if (req_valid[0])      grant = 3'b001;
               else if (req_valid[1]) grant = 3'b010;
               else if (req_valid[2]) grant = 3'b100;
            end
         endcase
      end
   end

   assign req_stall = req_valid & ~grant;

   always_comb begin
      rr_ptr_next = rr_ptr;
      unique case (grant)
         3'b001:  rr_ptr_next = 2'd1;
         3'b010:  rr_ptr_next = 2'd2;
         3'b100:  rr_ptr_next = 2'd0;
         default: rr_ptr_next = rr_ptr;
      endcase
   end

   always_comb begin
      sel_itype  = req_instruction_type[INSTR_TYPE_SZ-1:0];
      sel_pc     = req_pc[WORD_SIZE-1:0];
      sel_exc    = req_exception[0];
      sel_vaddr  = req_virtual_addr_exception[WORD_SIZE-1:0];
      sel_result = req_aluResult[WORD_SIZE-1:0];
      sel_rob    = req_rob_id[ROB_ENTRY_WIDTH-1:0];
      for (int i = 1; i < 3; i++) begin
         if (grant[i]) begin
            sel_itype  = req_instruction_type[i*INSTR_TYPE_SZ +: INSTR_TYPE_SZ];
            sel_pc     = req_pc[i*WORD_SIZE +: WORD_SIZE];
            sel_exc    = req_exception[i];
            sel_vaddr  = req_virtual_addr_exception[i*WORD_SIZE +: WORD_SIZE];
            sel_result = req_aluResult[i*WORD_SIZE +: WORD_SIZE];
            sel_rob    = req_rob_id[i*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr   <= 2'd0;
         itype_q  <= '0;
         pc_q     <= '0;
         exc_q    <= 1'b0;
         vaddr_q  <= '0;
         result_q <= '0;
         rob_q    <= '0;
         valid_q  <= 1'b0;
         grant_q  <= 3'b000;
      end else if (accept) begin
         rr_ptr <= rr_ptr_next;
         if (|grant) begin
            itype_q  <= sel_itype;
            pc_q     <= sel_pc;
            exc_q    <= sel_exc;
            vaddr_q  <= sel_vaddr;
            result_q <= sel_result;
            rob_q    <= sel_rob;
            valid_q  <= 1'b1;
            grant_q  <= grant;
         end else begin
            // Data fields keep their last values; only the valid/grant tags clear.
            valid_q <= 1'b0;
            grant_q <= 3'b000;
         end
      end
   end

   assign instruction_type_out       = itype_q;
   assign pc_out                     = pc_q;
   assign exception_out              = exc_q;
   assign virtual_addr_exception_out = vaddr_q;
   assign aluResult_out              = result_q;
   assign rob_id_out                 = rob_q;
   assign valid_out                  = valid_q;
   assign grant_out                  = grant_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

   localparam int W  = 32;
   localparam int IT = 4;
   localparam int RW = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic [2:0]      req_valid;
   logic [3*IT-1:0] req_instruction_type;
   logic [3*W-1:0]  req_pc;
   logic [2:0]      req_exception;
   logic [3*W-1:0]  req_virtual_addr_exception;
   logic [3*W-1:0]  req_aluResult;
   logic [3*RW-1:0] req_rob_id;
   logic            wb_stall;
   logic [2:0]      req_stall;
   logic [IT-1:0]   instruction_type_out;
   logic [W-1:0]    pc_out;
   logic            exception_out;
   logic [W-1:0]    virtual_addr_exception_out;
   logic [W-1:0]    aluResult_out;
   logic [RW-1:0]   rob_id_out;
   logic            valid_out;
   logic [2:0]      grant_out;

   int total = 0;
   int bad   = 0;

   wb_port_arbiter #(.WORD_SIZE(W), .INSTR_TYPE_SZ(IT), .ROB_ENTRY_WIDTH(RW)) dut (
      .clk                        (clk),
      .reset                      (reset),
      .req_valid                  (req_valid),
      .req_instruction_type       (req_instruction_type),
      .req_pc                     (req_pc),
      .req_exception              (req_exception),
      .req_virtual_addr_exception (req_virtual_addr_exception),
      .req_aluResult              (req_aluResult),
      .req_rob_id                 (req_rob_id),
      .wb_stall                   (wb_stall),
      .req_stall                  (req_stall),
      .instruction_type_out       (instruction_type_out),
      .pc_out                     (pc_out),
      .exception_out              (exception_out),
      .virtual_addr_exception_out (virtual_addr_exception_out),
      .aluResult_out              (aluResult_out),
      .rob_id_out                 (rob_id_out),
      .valid_out                  (valid_out),
      .grant_out                  (grant_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Settle inputs away from the edge, then advance one clock and sample 1 time unit after.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] pc, input logic [31:0] res,
                          input logic [4:0] rob, input logic exc, input logic [31:0] va);
      req_pc[i*W +: W]                     = pc;
      req_aluResult[i*W +: W]              = res;
      req_rob_id[i*RW +: RW]               = rob;
      req_exception[i]                     = exc;
      req_virtual_addr_exception[i*W +: W] = va;
      req_instruction_type[i*IT +: IT]     = 4'(i + 1);
   endtask

   initial begin
      reset     = 1'b1;
      wb_stall  = 1'b0;
      req_valid = 3'b101;
      req_instruction_type = '0;
      req_pc = '0; req_exception = '0; req_virtual_addr_exception = '0;
      req_aluResult = '0; req_rob_id = '0;
      for (int i = 0; i < 3; i++) set_req(i, 32'h100 + i, 32'hA0 + i, 5'(10 + i), 1'b0, 32'h0);
      #1;
      chk("stall_in_reset", req_stall, 3'b101);
      tick();
      tick();
      chk("rst_valid", valid_out, 0);
      chk("rst_grant", grant_out, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_rob", rob_id_out, 0);

      // Single request from the MEM pipe.
      reset     = 1'b0;
      req_valid = 3'b010;
      set_req(1, 32'h101, 32'hDEAD, 5'd5, 1'b0, 32'h0);
      #1;
      chk("single_stall", req_stall, 3'b000);
      tick();
      chk("single_valid", valid_out, 1);
      chk("single_rob", rob_id_out, 5);
      chk("single_alu", aluResult_out, 32'hDEAD);
      chk("single_grant", grant_out, 3'b010);
      chk("single_itype", instruction_type_out, 2);

      // Idle drain; pointer must stay at 2.
      req_valid = 3'b000;
      tick();
      chk("drain_valid", valid_out, 0);
      chk("drain_grant", grant_out, 0);
      chk("drain_data_hold", aluResult_out, 32'hDEAD);
      req_valid = 3'b111;
      #1;
      chk("ptr_kept_stall", req_stall, 3'b011);
      tick();
      chk("ptr_kept_grant", grant_out, 3'b100);
      chk("ptr_kept_pc", pc_out, 32'h102);

      // Round-robin with all three valid: grants 0,1,2,0.
      #1; chk("rr0_stall", req_stall, 3'b110);
      tick(); chk("rr0_grant", grant_out, 3'b001); chk("rr0_pc", pc_out, 32'h100);
      #1; chk("rr1_stall", req_stall, 3'b101);
      tick(); chk("rr1_grant", grant_out, 3'b010); chk("rr1_pc", pc_out, 32'h101);
      #1; chk("rr2_stall", req_stall, 3'b011);
      tick(); chk("rr2_grant", grant_out, 3'b100); chk("rr2_pc", pc_out, 32'h102);
      #1; chk("rr3_stall", req_stall, 3'b110);
      tick(); chk("rr3_grant", grant_out, 3'b001); chk("rr3_valid", valid_out, 1);

      // Downstream stall holding rob 3 (pointer now 1).
      req_valid = 3'b010;
      set_req(1, 32'h111, 32'h33, 5'd3, 1'b0, 32'h0);
      tick();
      chk("hold_load_rob", rob_id_out, 3);
      wb_stall  = 1'b1;
      req_valid = 3'b100;
      set_req(2, 32'h222, 32'h77, 5'd7, 1'b0, 32'h0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("hold_stall", req_stall, 3'b100);
         tick();
         chk("hold_rob", rob_id_out, 3);
         chk("hold_valid", valid_out, 1);
         chk("hold_grant", grant_out, 3'b010);
      end
      wb_stall = 1'b0;
      #1;
      chk("release_stall", req_stall, 3'b000);
      tick();
      chk("release_rob", rob_id_out, 7);
      chk("release_grant", grant_out, 3'b100);

      // Empty output register accepts even while wb_stall is high (pointer now 0).
      req_valid = 3'b000;
      tick();
      chk("empty_valid", valid_out, 0);
      wb_stall  = 1'b1;
      req_valid = 3'b001;
      set_req(0, 32'h300, 32'h99, 5'd9, 1'b0, 32'h0);
      #1;
      chk("empty_stall", req_stall, 3'b000);
      tick();
      chk("empty_load_valid", valid_out, 1);
      chk("empty_load_grant", grant_out, 3'b001);
      chk("empty_load_rob", rob_id_out, 9);

      // Reset while a stalled writeback is held (pointer is 1 before reset).
      req_valid = 3'b011;
      #1;
      chk("full_stall_stall", req_stall, 3'b011);
      reset = 1'b1;
      #1;
      chk("midrst_stall", req_stall, 3'b011);
      tick();
      chk("midrst_valid", valid_out, 0);
      chk("midrst_grant", grant_out, 0);
      chk("midrst_pc", pc_out, 0);
      chk("midrst_alu", aluResult_out, 0);
      chk("midrst_rob", rob_id_out, 0);
      chk("midrst_itype", instruction_type_out, 0);
      reset    = 1'b0;
      wb_stall = 1'b0;
      #1;
      chk("post_rst_stall", req_stall, 3'b010);
      tick();
      chk("post_rst_grant", grant_out, 3'b001);
      chk("post_rst_pc", pc_out, 32'h300);

      // Exception flag does not change priority (pointer now 1).
      set_req(1, 32'h400, 32'h44, 5'd4, 1'b1, 32'hBAD0);
      set_req(0, 32'h500, 32'h55, 5'd6, 1'b0, 32'h0);
      tick();
      chk("exc_grant", grant_out, 3'b010);
      chk("exc_flag", exception_out, 1);
      chk("exc_vaddr", virtual_addr_exception_out, 32'hBAD0);
      tick();
      chk("exc_next_grant", grant_out, 3'b001);
      chk("exc_next_flag", exception_out, 0);
      chk("exc_next_rob", rob_id_out, 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
